// File: rtl/posit_n32_es6_pkg.sv
// Shared constants and types for posit<32,6> arithmetic units.
// Holds the unpacked operand format consumed by the encoder and future mul/div/convert units.
package posit_n32_es6_pkg;

   localparam int N  = 32;
   localparam int ES = 6;
   localparam int BS = 5;
   localparam int SW = ES + BS + 2;

   localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
   localparam logic [N-1:0] MINPOS = 32'h0000_0001;
   localparam logic [N-1:0] NAR    = 32'h8000_0000;

   typedef logic signed [SW-1:0] scale_t;

   // Scales outside [SCALE_MIN, SCALE_MAX) need a regime longer than the posit can hold.
   localparam scale_t SCALE_MAX = 13'sd1920;
   localparam scale_t SCALE_MIN = -13'sd1920;

   typedef struct packed {
      logic           sign;
      scale_t         scale;
      logic [N-1:0]   mant;
      logic           sticky;
      logic           zero;
      logic           inf;
   } posit_unpacked_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on the kept posit body bits.
// Purely combinational; the caller guarantees the increment never reaches bit N-1.
module posit_round_rne
   import posit_n32_es6_pkg::*;
(
   input  logic [N-2:0] kept_i,
   input  logic         lsb_i,
   input  logic         guard_i,
   input  logic         sticky_i,
   output logic [N-1:0] mag_o
);

   assign mag_o = {1'b0, kept_i} + {{(N-1){1'b0}}, guard_i & (lsb_i | sticky_i)};

endmodule

// File: rtl/posit_encode_n32_es6_pipe.sv
// Three-stage posit<32,6> encoder: sign/scale/mantissa/specials -> packed RNE-rounded posit.
// Define POSIT_ENC_SAT_FLAG_EN to add a registered 'sat' output flagging saturated results.
module posit_encode_n32_es6_pipe
   import posit_n32_es6_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sign,
   input  logic [SW-1:0] scale,
   input  logic [N-1:0]  mant,
   input  logic          sticky_in,
   input  logic          zero_in,
   input  logic          inf_in,
   output logic [N-1:0]  out,
   output logic          done,
   output logic          inf,
`ifdef POSIT_ENC_SAT_FLAG_EN
   output logic          sat,
`endif
   output logic          zero
);

   localparam int VW = 2*N + ES - 1;

   // ---------------- stage 1: regime decode ----------------
   posit_unpacked_t op;
   logic            fill;
   logic [BS-1:0]   rl_d;

   assign op   = '{sign: sign, scale: scale, mant: mant, sticky: sticky_in, zero: zero_in, inf: inf_in};
   assign fill = ~op.scale[SW-1];
   // Run length is k+1 for k>=0 and -k (= ~k+1) for k<0; both fit BS bits in the non-saturated range.
   assign rl_d = (fill ? op.scale[ES+BS-1:ES] : ~op.scale[ES+BS-1:ES]) + BS'(1);

   logic            s1_v_q, s2_v_q;
   logic            s1_sign_q, s1_fill_q, s1_sticky_q, s1_zero_q, s1_inf_q, s1_smax_q, s1_smin_q;
   logic [BS-1:0]   s1_rl_q;
   logic [ES-1:0]   s1_exp_q;
   logic [N-2:0]    s1_frac_q;

   // NOTE: datapath registers have no reset; only valid bits and outputs need a defined state.
   always_ff @(posedge clk) begin
      s1_sign_q   <= op.sign;
      s1_fill_q   <= fill;
      s1_rl_q     <= rl_d;
      s1_exp_q    <= op.scale[ES-1:0];
      s1_frac_q   <= op.mant[N-2:0];
      s1_sticky_q <= op.sticky;
      s1_zero_q   <= op.zero;
      s1_inf_q    <= op.inf;
      s1_smax_q   <= op.scale >= SCALE_MAX;
      s1_smin_q   <= op.scale < SCALE_MIN;
   end

   // ---------------- stage 2: regime insertion and bit split ----------------
   logic [VW-1:0]   body, shifted;
   logic [N-2:0]    kept_d;
   logic            g_d, st_d;

   assign body    = {~s1_fill_q, s1_exp_q, s1_frac_q, {(N-1){1'b0}}};
   assign shifted = (body >> s1_rl_q) | ({VW{s1_fill_q}} & ~({VW{1'b1}} >> s1_rl_q));
   assign kept_d  = shifted[VW-1 -: N-1];
   assign g_d     = shifted[VW-N];
   assign st_d    = (|shifted[VW-N-1:0]) | s1_sticky_q;

   logic            s2_sign_q, s2_g_q, s2_st_q, s2_zero_q, s2_inf_q, s2_smax_q, s2_smin_q;
   logic [N-2:0]    s2_kept_q;

   always_ff @(posedge clk) begin
      s2_kept_q <= kept_d;
      s2_g_q    <= g_d;
      s2_st_q   <= st_d;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_inf_q  <= s1_inf_q;
      s2_smax_q <= s1_smax_q;
      s2_smin_q <= s1_smin_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
      end else begin
         s1_v_q <= start;
         s2_v_q <= s1_v_q;
      end
   end

   // ---------------- stage 3: round, saturate, negate, specials ----------------
   logic [N-1:0]    rnd_mag, mag, out_d;
   logic            inf_d, zero_d;

   posit_round_rne u_round (
      .kept_i   (s2_kept_q),
      .lsb_i    (s2_kept_q[0]),
      .guard_i  (s2_g_q),
      .sticky_i (s2_st_q),
      .mag_o    (rnd_mag)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mag    = rnd_mag;
      inf_d  = 1'b0;
      zero_d = 1'b0;
      if (s2_smax_q)      mag = MAXPOS;
      else if (s2_smin_q) mag = MINPOS;
      out_d = s2_sign_q ? -mag : mag;
      if (s2_inf_q) begin
         out_d = NAR;
         inf_d = 1'b1;
      end else if (s2_zero_q) begin
         out_d  = '0;
         zero_d = 1'b1;
      end
   end

   logic [N-1:0]    out_q;
   logic            done_q, inf_q, zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         out_q  <= '0;
         inf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         done_q <= s2_v_q;
         if (s2_v_q) begin
            out_q  <= out_d;
            inf_q  <= inf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign inf  = inf_q;
   assign zero = zero_q;

`ifdef POSIT_ENC_SAT_FLAG_EN
   logic sat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sat_q <= 1'b0;
      else if (s2_v_q) sat_q <= (s2_smax_q | s2_smin_q) & ~s2_inf_q & ~s2_zero_q;
   end

   assign sat = sat_q;
`endif

   // Saturation bounds keep the RNE increment out of the sign bit.
   assert property (@(posedge clk) disable iff (!rst_n)
      s2_v_q && !s2_inf_q && !s2_zero_q && !s2_smax_q && !s2_smin_q |-> !rnd_mag[N-1]);

   assert property (@(posedge clk) disable iff (!rst_n)
      start && !zero_in && !inf_in |-> op.mant[N-1]);

endmodule

// File: tb/tb_posit_encode_n32_es6_pipe.sv
// Scoreboard bench for posit_encode_n32_es6_pipe: directed constants plus a bit-string reference model.
// Honours POSIT_ENC_SAT_FLAG_EN by also checking the sat output.
module tb_posit_encode_n32_es6_pipe;

   typedef struct {
      logic [31:0] out;
      logic        inf;
      logic        zero;
      logic        sat;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, sign, sticky_in, zero_in, inf_in;
   logic [12:0] scale;
   logic [31:0] mant;
   logic [31:0] out;
   logic        done, inf, zero;
`ifdef POSIT_ENC_SAT_FLAG_EN
   logic        sat;
`endif

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   posit_encode_n32_es6_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sign      (sign),
      .scale     (scale),
      .mant      (mant),
      .sticky_in (sticky_in),
      .zero_in   (zero_in),
      .inf_in    (inf_in),
      .out       (out),
      .done      (done),
      .inf       (inf),
`ifdef POSIT_ENC_SAT_FLAG_EN
      .sat       (sat),
`endif
      .zero      (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: spell out the posit bit string (regime, exponent, fraction), cut at 31 bits, round RNE.
   function automatic exp_t model(logic s, int sc, logic [31:0] m, logic st_in, logic z, logic nar);
      exp_t        r;
      bit          bits[$];
      int          k, e;
      logic [31:0] mag;
      logic        g, st;
      r = '{default: 0};
      if (sc >= 0) k = sc / 64;
      else         k = -((-sc + 63) / 64);
      e = sc - 64 * k;
      if (nar) begin
         r.out = 32'h8000_0000;
         r.inf = 1'b1;
         return r;
      end
      if (z) begin
         r.zero = 1'b1;
         return r;
      end
      if (k >= 30) begin
         mag = 32'h7FFF_FFFF;
         r.sat = 1'b1;
      end else if (k < -30) begin
         mag = 32'h0000_0001;
         r.sat = 1'b1;
      end else begin
         if (k >= 0) begin
            repeat (k + 1) bits.push_back(1'b1);
            bits.push_back(1'b0);
         end else begin
            repeat (-k) bits.push_back(1'b0);
            bits.push_back(1'b1);
         end
         for (int i = 5; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
         for (int i = 30; i >= 0; i--) bits.push_back(m[i]);
         mag = '0;
         for (int i = 0; i < 31; i++) mag = {mag[30:0], bits[i]};
         g  = bits[31];
         st = st_in;
         for (int i = 32; i < bits.size(); i++) st = st | bits[i];
         if (g && (mag[0] || st)) mag = mag + 1;
      end
      r.out = s ? (~mag + 32'd1) : mag;
      return r;
   endfunction

   // Called at a negedge: presents one operand for one cycle, optionally logging its expectation.
   task automatic send(input logic s, input int sc, input logic [31:0] m, input logic st,
                       input logic z, input logic nar, input bit push, input exp_t ex);
      start     = 1'b1;
      sign      = s;
      scale     = sc[12:0];
      mant      = m;
      sticky_in = st;
      zero_in   = z;
      inf_in    = nar;
      if (push) begin
         ex.due = cyc + 3;
         sb.push_back(ex);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_dir(input logic s, input int sc, input logic [31:0] m, input logic st,
                           input logic z, input logic nar, input logic [31:0] eo,
                           input logic ei, input logic ez, input logic es);
      exp_t ex;
      ex = '{out: eo, inf: ei, zero: ez, sat: es, due: 0};
      send(s, sc, m, st, z, nar, 1'b1, ex);
   endtask

   task automatic send_model(input logic s, input int sc, input logic [31:0] m, input logic st,
                             input logic z, input logic nar);
      send(s, sc, m, st, z, nar, 1'b1, model(s, sc, m, st, z, nar));
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      check(name, 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t ex;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            ex = sb.pop_front();
            check("out", 64'(out), 64'(ex.out));
            check("inf", 64'(inf), 64'(ex.inf));
            check("zero", 64'(zero), 64'(ex.zero));
`ifdef POSIT_ENC_SAT_FLAG_EN
            check("sat", 64'(sat), 64'(ex.sat));
`endif
            check("latency", 64'(cyc), 64'(ex.due));
         end
      end
   end

   initial begin
      exp_t        dummy;
      int          sc, n_done;
      logic [31:0] m;
      dummy = '{default: 0};
      rst_n = 1'b0;
      start = 1'b0; sign = 1'b0; scale = '0; mant = '0;
      sticky_in = 1'b0; zero_in = 1'b0; inf_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", 64'(out), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_inf", 64'(inf), 64'd0);
      check("reset_zero", 64'(zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: basic encodes, RNE, saturation boundaries, specials.
      send_dir(0, 0,     32'h8000_0000, 0, 0, 0, 32'h4000_0000, 0, 0, 0);
      send_dir(1, 0,     32'h8000_0000, 0, 0, 0, 32'hC000_0000, 0, 0, 0);
      send_dir(0, 64,    32'h8000_0000, 0, 0, 0, 32'h6000_0000, 0, 0, 0);
      send_dir(0, -1,    32'h8000_0000, 0, 0, 0, 32'h3F80_0000, 0, 0, 0);
      send_dir(0, 0,     32'h8000_0080, 0, 0, 0, 32'h4000_0000, 0, 0, 0);
      send_dir(0, 0,     32'h8000_0180, 0, 0, 0, 32'h4000_0002, 0, 0, 0);
      send_dir(0, 0,     32'h8000_0080, 1, 0, 0, 32'h4000_0001, 0, 0, 0);
      send_dir(0, 2000,  32'h8000_0000, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 1);
      send_dir(0, -2000, 32'h8000_0000, 0, 0, 0, 32'h0000_0001, 0, 0, 1);
      send_dir(1, 2000,  32'h8000_0000, 0, 0, 0, 32'h8000_0001, 0, 0, 1);
      send_dir(0, 1919,  32'h8000_0000, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0);
      send_dir(0, 1920,  32'h8000_0000, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 1);
      send_dir(0, -1920, 32'h8000_0000, 0, 0, 0, 32'h0000_0001, 0, 0, 0);
      send_dir(0, -1921, 32'h8000_0000, 0, 0, 0, 32'h0000_0001, 0, 0, 1);
      send_dir(0, 2000,  32'h8000_0000, 0, 1, 1, 32'h8000_0000, 1, 0, 0);
      send_dir(1, -2000, 32'h8000_0000, 0, 1, 0, 32'h0000_0000, 0, 1, 0);
      drain("drain_directed");

      // Streaming: ten back-to-back operands with distinct scales.
      for (int i = 0; i < 10; i++)
         send_model(i[0], i * 173 - 800, {1'b1, 31'($urandom)}, 1'($urandom), 0, 0);
      drain("drain_stream");

      // Random traffic with idle gaps and occasional specials.
      for (int i = 0; i < 300; i++) begin
         sc = int'($urandom_range(0, 4400)) - 2200;
         m  = {1'b1, 31'($urandom)};
         send_model(1'($urandom), sc, m, 1'($urandom),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain("drain_random");

      // Reset with two operands in flight: nothing may emerge afterwards.
      send(0, 64, 32'h8000_0000, 0, 0, 0, 1'b0, dummy);
      send(1, 128, 32'h8000_0000, 0, 0, 0, 1'b0, dummy);
      @(posedge clk);
      #1;
      check("pre_reset_done", 64'(done), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_done", 64'(done), 64'd0);
      check("rst_out", 64'(out), 64'd0);
      check("rst_inf", 64'(inf), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("no_done_after_reset", 64'(n_done), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
